vga_timing: RTL

- Generates 800x600 @60 Hz VGA raster timing from a 40 MHz pixel clock.
- Outputs hcount, vcount, hsync, hblnk, vsync and vblnk. Sits directly upstream of the start/game screen drawing stages, which register these signals and add rgb.
- Also emits a one-cycle frame tick for frame-based animation and countdown logic downstream.

---
 rtl/vga_timing.sv | 89 ++++++++
 1 files changed

// File: rtl/vga_timing.sv
// 800x600@60 raster timing generator: free-running h/v counters with
// sync/blank decodes and a frame tick, all registered and cycle-aligned.
module vga_timing #(
  parameter int H_VISIBLE = 800,
  parameter int H_FRONT   = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BACK    = 88,
  parameter int V_VISIBLE = 600,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BACK    = 23
) (
  input  logic        pclk,
  input  logic        reset,
  output logic [10:0] hcount,
  output logic        hsync,
  output logic        hblnk,
  output logic [10:0] vcount,
  output logic        vsync,
  output logic        vblnk,
  output logic        frame_tick
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] HB_START = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] VB_START = 11'(V_VISIBLE);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [10:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic        hsync_q, hsync_d, hblnk_q, hblnk_d;
  logic        vsync_q, vsync_d, vblnk_q, vblnk_d;
  logic        frame_tick_q, frame_tick_d;
  logic [10:0] hcount_nxt, vcount_nxt;
  logic        hwrap, vwrap;

  always_comb begin
    hwrap      = (hcount_q == H_LAST);
    vwrap      = (vcount_q == V_LAST);
    hcount_nxt = hwrap ? 11'd0 : hcount_q + 11'd1;
    vcount_nxt = vcount_q;
    if (hwrap) vcount_nxt = vwrap ? 11'd0 : vcount_q + 11'd1;
  end

  // Decodes look at the next counts so they land in the same register stage.
  always_comb begin
    hcount_d     = hcount_nxt;
    vcount_d     = vcount_nxt;
    hblnk_d      = (hcount_nxt >= HB_START);
    hsync_d      = (hcount_nxt >= HS_START) && (hcount_nxt <= HS_END);
    vblnk_d      = (vcount_nxt >= VB_START);
    vsync_d      = (vcount_nxt >= VS_START) && (vcount_nxt <= VS_END);
    frame_tick_d = hwrap && vwrap;
    if (reset) begin
      hcount_d     = 11'd0;
      vcount_d     = 11'd0;
      hblnk_d      = 1'b0;
      hsync_d      = 1'b0;
      vblnk_d      = 1'b0;
      vsync_d      = 1'b0;
      frame_tick_d = 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    hcount_q     <= hcount_d;
    vcount_q     <= vcount_d;
    hblnk_q      <= hblnk_d;
    hsync_q      <= hsync_d;
    vblnk_q      <= vblnk_d;
    vsync_q      <= vsync_d;
    frame_tick_q <= frame_tick_d;
  end

  assign hcount     = hcount_q;
  assign vcount     = vcount_q;
  assign hblnk      = hblnk_q;
  assign hsync      = hsync_q;
  assign vblnk      = vblnk_q;
  assign vsync      = vsync_q;
  assign frame_tick = frame_tick_q;

endmodule
